// File: rtl/mem_monitor_pkg.sv
// Shared types and helpers for the data-memory write monitor.
//   mon_state_t : monitor FSM states (IDLE, RUN, PASS, FAIL)
//   idx_width() : width of a slot index, never less than 1 bit
package mem_monitor_pkg;

    typedef enum logic [1:0] {
        MON_IDLE = 2'd0,
        MON_RUN  = 2'd1,
        MON_PASS = 2'd2,
        MON_FAIL = 2'd3
    } mon_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_write_monitor_sig_matcher.sv
// sig_matcher: combinational comparison of one bus store against the
// signature table.
//   memwrite/dataadr/writedata : snooped store (memwrite != 0 means a write)
//   sig_en/sig_addr/sig_data   : per-slot enable and flattened table
//   hit/hit_idx                : full (address and data) match, lowest slot wins
//   addr_hit/addr_hit_idx      : address matches but data differs, lowest slot wins
module sig_matcher
    import mem_monitor_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int NUM_SIG = 4,
    parameter int IDX_W   = idx_width(NUM_SIG)
) (
    input  logic [1:0]                memwrite,
    input  logic [ADDR_W-1:0]         dataadr,
    input  logic [DATA_W-1:0]         writedata,
    input  logic [NUM_SIG-1:0]        sig_en,
    input  logic [NUM_SIG*ADDR_W-1:0] sig_addr,
    input  logic [NUM_SIG*DATA_W-1:0] sig_data,
    output logic                      hit,
    output logic [IDX_W-1:0]          hit_idx,
    output logic                      addr_hit,
    output logic [IDX_W-1:0]          addr_hit_idx
);

    logic wr;
    assign wr = |memwrite;

    // Scanning from the top slot down lets the lowest matching slot
    // overwrite any higher one, giving a lowest-index priority encoder.
    always_comb begin
        hit          = 1'b0;
        hit_idx      = '0;
        addr_hit     = 1'b0;
        addr_hit_idx = '0;
        for (int i = NUM_SIG - 1; i >= 0; i--) begin
            if (wr && sig_en[i] && (dataadr == sig_addr[i*ADDR_W +: ADDR_W])) begin
                if (writedata == sig_data[i*DATA_W +: DATA_W]) begin
                    hit     = 1'b1;
                    hit_idx = IDX_W'(i);
                end else begin
                    addr_hit     = 1'b1;
                    addr_hit_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_write_monitor.sv
// mem_write_monitor: self-check monitor on the CPU data-memory write bus.
// Once started it waits for a store matching any enabled signature slot
// (PASS) or for the watchdog to expire (FAIL); both outcomes are sticky
// until clear or reset.
// Optional build macro MEM_WRITE_MONITOR_MISMATCH_EN: a store to an enabled
// slot address carrying the wrong data also ends in FAIL.
// Ports:
//   clk, reset             : rising-edge clock, synchronous active-high reset
//   start, clear           : arm (IDLE->RUN), return to IDLE from any state
//   memwrite/dataadr/writedata : snooped store bus
//   sig_en/sig_addr/sig_data   : signature table (slot i at [i*W +: W])
//   pass, fail, done       : sticky status, done = pass | fail
//   match_idx              : slot responsible for the final state
//   cycle_cnt              : cycles spent in RUN, frozen on PASS/FAIL
//   dbg_state              : current FSM state
module mem_write_monitor
    import mem_monitor_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int NUM_SIG = 4,
    parameter int CNT_W   = 10,
    parameter int TIMEOUT = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         clear,
    input  logic [1:0]                   memwrite,
    input  logic [ADDR_W-1:0]            dataadr,
    input  logic [DATA_W-1:0]            writedata,
    input  logic [NUM_SIG-1:0]           sig_en,
    input  logic [NUM_SIG*ADDR_W-1:0]    sig_addr,
    input  logic [NUM_SIG*DATA_W-1:0]    sig_data,
    output logic                         pass,
    output logic                         fail,
    output logic                         done,
    output logic [idx_width(NUM_SIG)-1:0] match_idx,
    output logic [CNT_W-1:0]             cycle_cnt,
    output mon_state_t                   dbg_state
);

    localparam int IDX_W = idx_width(NUM_SIG);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    mon_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;

    logic             hit, addr_hit;
    logic [IDX_W-1:0] hit_idx, addr_hit_idx;

    sig_matcher #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_SIG (NUM_SIG),
        .IDX_W   (IDX_W)
    ) u_matcher (
        .memwrite     (memwrite),
        .dataadr      (dataadr),
        .writedata    (writedata),
        .sig_en       (sig_en),
        .sig_addr     (sig_addr),
        .sig_data     (sig_data),
        .hit          (hit),
        .hit_idx      (hit_idx),
        .addr_hit     (addr_hit),
        .addr_hit_idx (addr_hit_idx)
    );

`ifndef MEM_WRITE_MONITOR_MISMATCH_EN
    // Wrong-data detection is compiled out; keep the matcher outputs tied off.
    logic unused_mismatch;
    assign unused_mismatch = ^{addr_hit, addr_hit_idx};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MON_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        if (clear) begin
            state_n = MON_IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end else begin
            case (state)
                MON_IDLE: begin
                    cnt_n = '0;
                    if (start) state_n = MON_RUN;
                end
                MON_RUN: begin
                    // The counter advances only while staying in RUN, so it
                    // freezes at the value seen on the deciding cycle.
                    // A match takes precedence over the watchdog.
                    if (hit) begin
                        state_n = MON_PASS;
                        idx_n   = hit_idx;
`ifdef MEM_WRITE_MONITOR_MISMATCH_EN
                    end else if (addr_hit) begin
                        state_n = MON_FAIL;
                        idx_n   = addr_hit_idx;
`endif
                    end else if (cnt == LAST_CNT) begin
                        state_n = MON_FAIL;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: ;  // PASS and FAIL hold until clear/reset
            endcase
        end
    end

    assign pass      = (state == MON_PASS);
    assign fail      = (state == MON_FAIL);
    assign done      = pass | fail;
    assign match_idx = idx;
    assign cycle_cnt = cnt;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_write_monitor.sv
module tb_mem_write_monitor;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 64;
    localparam int NUM_SIG = 4;
    localparam int CNT_W   = 10;
    localparam int TIMEOUT = 32;
    localparam int IDX_W   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset, start, clear;
    logic [1:0]                memwrite;
    logic [ADDR_W-1:0]         dataadr;
    logic [DATA_W-1:0]         writedata;
    logic [NUM_SIG-1:0]        sig_en;
    logic [ADDR_W-1:0]         sa [NUM_SIG];
    logic [DATA_W-1:0]         sd [NUM_SIG];
    logic [NUM_SIG*ADDR_W-1:0] sig_addr;
    logic [NUM_SIG*DATA_W-1:0] sig_data;

    logic             pass, fail, done;
    logic [IDX_W-1:0] match_idx;
    logic [CNT_W-1:0] cycle_cnt;
    logic [1:0]       dbg_state;

    always_comb begin
        sig_addr = '0;
        sig_data = '0;
        for (int i = 0; i < NUM_SIG; i++) begin
            sig_addr[i*ADDR_W +: ADDR_W] = sa[i];
            sig_data[i*DATA_W +: DATA_W] = sd[i];
        end
    end

    mem_write_monitor #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NUM_SIG (NUM_SIG),
        .CNT_W (CNT_W), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .reset (reset), .start (start), .clear (clear),
        .memwrite (memwrite), .dataadr (dataadr), .writedata (writedata),
        .sig_en (sig_en), .sig_addr (sig_addr), .sig_data (sig_data),
        .pass (pass), .fail (fail), .done (done), .match_idx (match_idx),
        .cycle_cnt (cycle_cnt), .dbg_state (dbg_state)
    );

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 running, 2 passed, 3 failed
    int m_phase = 0;
    int m_cnt   = 0;
    int m_idx   = 0;
    int errors  = 0;
    int checks  = 0;

    // Lowest enabled slot hit by the current store; want_data selects a
    // full match (1) or an address-only match with wrong data (0).
    function automatic int find_slot(input bit want_data);
        if (memwrite == 2'd0) return -1;
        for (int i = 0; i < NUM_SIG; i++) begin
            if (sig_en[i] && dataadr == sa[i] && ((writedata == sd[i]) == want_data))
                return i;
        end
        return -1;
    endfunction

    function automatic void model_update();
        int s;
        if (reset || clear) begin
            m_phase = 0; m_cnt = 0; m_idx = 0;
        end else if (m_phase == 0) begin
            m_cnt = 0;
            if (start) m_phase = 1;
        end else if (m_phase == 1) begin
            s = find_slot(1'b1);
            if (s >= 0) begin
                m_phase = 2; m_idx = s;
            end else begin
`ifdef MEM_WRITE_MONITOR_MISMATCH_EN
                s = find_slot(1'b0);
`else
                s = -1;
`endif
                if (s >= 0) begin
                    m_phase = 3; m_idx = s;
                end else if (m_cnt == TIMEOUT - 1) begin
                    m_phase = 3;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("pass",      64'(pass),      64'(m_phase == 2));
        check("fail",      64'(fail),      64'(m_phase == 3));
        check("done",      64'(done),      64'(m_phase >= 2));
        check("match_idx", 64'(match_idx), 64'(m_idx));
        check("cycle_cnt", 64'(cycle_cnt), 64'(m_cnt));
        check("state",     64'(dbg_state), 64'(m_phase));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic bus_idle();
        start = 0; clear = 0; reset = 0;
        memwrite  = 2'd0;
        dataadr   = 64'($urandom_range(0, 255));
        writedata = 64'($urandom_range(0, 15));
    endtask

    task automatic write(input logic [1:0] mw, input int a, input int d);
        memwrite = mw; dataadr = 64'(a); writedata = 64'(d);
        step();
        bus_idle();
    endtask

    task automatic do_start();
        bus_idle(); start = 1; step(); start = 0;
    endtask

    task automatic do_clear();
        bus_idle(); clear = 1; step(); clear = 0;
    endtask

    // Idle the bus until the model's running counter reaches target or the
    // run ends; a run that never gets there is a failure.
    task automatic run_until(input int target);
        int n = 0;
        while (m_phase == 1 && m_cnt != target) begin
            if (n >= 200) begin
                checks++; errors++;
                $error("FAIL run_until observed=%0d expected=%0d", m_cnt, target);
                break;
            end
            bus_idle();
            step();
            n++;
        end
    endtask

    task automatic set_slot(input int i, input int a, input int d);
        sa[i] = 64'(a); sd[i] = 64'(d);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus_idle();
        reset = 1;
        set_slot(0, 84, 7); set_slot(1, 128, 7); set_slot(2, 80, 1); set_slot(3, 0, 0);
        sig_en = 4'b0111;
        step(); step();
        reset = 0;
        step();

        // Expected write at RUN cycle 5
        do_start();
        run_until(5);
        write(2'd1, 128, 7);
        step(); write(2'd3, 84, 7); step();

        // Watchdog timeout, then late matching write ignored
        do_clear();
        do_start();
        run_until(TIMEOUT - 1);
        step();
        write(2'd1, 84, 7);
        step();

        // Match on the very last cycle beats the watchdog
        do_clear();
        do_start();
        run_until(TIMEOUT - 1);
        write(2'd2, 80, 1);

        // Duplicate signatures: lowest enabled slot wins
        do_clear();
        set_slot(3, 84, 7); sig_en = 4'b1111;
        do_start();
        write(2'd1, 84, 7);
        do_clear();
        sig_en = 4'b1110;
        do_start();
        write(2'd1, 84, 7);

        // memwrite=0 never matches; clear from PASS; reset mid-run
        do_clear();
        sig_en = 4'b0111;
        do_start();
        write(2'd0, 84, 7);
        write(2'd0, 128, 7);
        write(2'd2, 128, 7);
        do_clear();
        do_start();
        run_until(10);
        bus_idle(); reset = 1; step(); reset = 0;
        step();

        // Wrong data to a signature address, then let the watchdog run
        do_start();
        step();
        write(2'd1, 84, 6);
        run_until(TIMEOUT - 1);
        step(); step();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (c % 150 == 0) begin
                for (int i = 0; i < NUM_SIG; i++) begin
                    case ($urandom_range(0, 2))
                        0: set_slot(i, 80, 1);
                        1: set_slot(i, 84, 7);
                        default: set_slot(i, 128, int'($urandom_range(6, 7)));
                    endcase
                end
                sig_en = 4'($urandom_range(0, 15));
            end
            reset = ($urandom_range(0, 99) == 0);
            clear = ($urandom_range(0, 24) == 0);
            start = ($urandom_range(0, 3) == 0);
            memwrite = ($urandom_range(0, 3) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            case ($urandom_range(0, 4))
                0: dataadr = 64'd80;
                1: dataadr = 64'd84;
                2: dataadr = 64'd128;
                3: dataadr = 64'($urandom_range(0, 255));
                default: dataadr = sa[$urandom_range(0, NUM_SIG - 1)];
            endcase
            writedata = ($urandom_range(0, 2) == 0) ? 64'd1 : 64'($urandom_range(5, 7));
            // Keep matches sparse enough that the watchdog also fires.
            if ($urandom_range(0, 3) != 0) memwrite = 2'd0;
            step();
        end

        bus_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_write_monitor.md
Name: mem_write_monitor

Overview:
- Synthesizable, parametrised self-check monitor for the CPU data-memory write bus.
- Compares each store against a programmable table of NUM_SIG expected (address, data) signatures and runs a cycle watchdog.
- Reports sticky pass, fail and done status plus the matched signature index.
- Sits beside top, snooping memwrite/dataadr/writedata; used both by the bench and by on-board status LEDs.

Parameters:
- DATA_W, 64, width of writedata and signature data.
- ADDR_W, 64, width of dataadr and signature addresses.
- NUM_SIG, 4, number of signature slots (≥1).
- CNT_W, 10, width of the watchdog cycle counter.
- TIMEOUT, 32, cycles in RUN before FAIL (1 ≤ TIMEOUT ≤ 2^CNT_W−1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  arms the monitor (IDLE→RUN).
- clear  in  1  synchronous return to IDLE from any state.
- memwrite  in  2  store strobe; any nonzero value is a write.
- dataadr  in  ADDR_W  store address.
- writedata  in  DATA_W  store data.
- sig_en  in  NUM_SIG  per-slot enable.
- sig_addr  in  NUM_SIG*ADDR_W  flattened slot addresses; slot i = bits [i*ADDR_W +: ADDR_W].
- sig_data  in  NUM_SIG*DATA_W  flattened slot data, same packing.
- pass  out  1  sticky: an expected write was seen.
- fail  out  1  sticky: watchdog expired (or mismatch, see the optional feature).
- done  out  1  pass | fail.
- match_idx  out  $clog2(NUM_SIG) (min 1)  slot that caused pass.
- cycle_cnt  out  CNT_W  cycles elapsed in RUN.

Behaviour:
- Reset state: IDLE. pass=0, fail=0, done=0, match_idx=0, cycle_cnt=0.
- States: IDLE, RUN, PASS, FAIL.
  - IDLE: cycle_cnt held at 0; bus ignored; start=1 → RUN next cycle.
  - RUN: cycle_cnt increments by 1 per cycle, starting from 0 on the first RUN cycle.
- Match: memwrite≠0, sig_en[i]=1, dataadr==sig_addr slot i, and writedata==sig_data slot i, all exact full-width compares. Evaluated only in RUN.
- Multiple simultaneous slot matches: the lowest index wins.
- Matching cycle: go to PASS; pass, done and match_idx are registered and visible one cycle later.
- Timeout: in RUN with no match and cycle_cnt==TIMEOUT−1, go to FAIL; fail and done assert next cycle.
- Match and timeout in the same cycle: match wins (PASS).
- PASS and FAIL are sticky. The bus, start and the counter are ignored; cycle_cnt freezes at its final value.
- clear: any state → IDLE next cycle, with all outputs back to their reset values. Priority order: reset > clear > start.
- start while in RUN has no effect (no counter restart).
- Writes with memwrite=0 never match, whatever the address or data.
- Reset asserted mid-RUN aborts immediately; the next cycle is IDLE with reset values.
- pass and fail are never both 1.

Optional Feature:
- Macro: MEM_WRITE_MONITOR_MISMATCH_EN.
- Defined: in RUN, a write with memwrite≠0 to an enabled slot address whose data differs from that slot's data (and no full match elsewhere) → FAIL next cycle. match_idx latches the lowest such slot.
- Undefined: wrong-data writes to signature addresses are ignored; FAIL comes only from the watchdog.

Decomposition:
- Package mem_monitor_pkg:
  - mon_state_t enum {MON_IDLE, MON_RUN, MON_PASS, MON_FAIL}.
  - Localparam helper for the index width (max(1, $clog2(NUM_SIG))).
- Sub-module sig_matcher: purely combinational. Inputs: bus, table and sig_en. Outputs: hit, hit_idx (lowest-index priority encoder), and addr_hit/addr_hit_idx for the mismatch option.
- mem_write_monitor holds the FSM, counter and output registers.

Test Plan:
- Defaults; slot0=(84,7), slot1=(128,7), slot2=(80,1); start; write (128,7) at RUN cycle 5 → next cycle pass=1, done=1, match_idx=1, cycle_cnt frozen at 5.
- No matching writes → fail=1 the cycle after cycle_cnt==31; pass stays 0; later write (84,7) does not change state.
- Write (80,1) exactly at cycle_cnt==31 → PASS, not FAIL, match_idx=2.
- slot0=slot3=(84,7), both enabled, write (84,7) → match_idx=0. Same write with sig_en[0]=0 → match_idx=3.
- memwrite=0 with dataadr=84, writedata=7 → no pass. In PASS, clear=1 → IDLE next cycle, all outputs 0. Reset at RUN cycle 10 → IDLE next cycle, cycle_cnt=0.
- With MEM_WRITE_MONITOR_MISMATCH_EN: write (84,6) → fail=1, match_idx=0. Without the macro: no change, watchdog still fails at 32.
